// File: rtl/ball_motion.sv
// rtl/ball_motion.sv - Pong ball engine: motion, bounces, miss detection, scoring and serve
module ball_motion #(
    parameter int ScreenWidth  = 1280,
    parameter int yTopBar      = 100,
    parameter int yBottomBar   = 924,
    parameter int PaddleHeight = 200,
    parameter int PaddleWidth  = 20,
    parameter int xLeftPaddle  = 40,
    parameter int xRightPaddle = 1220,
    parameter int BallSize     = 16,
    parameter int xBallInit    = 632,
    parameter int yBallInit    = 504,
    parameter int ServeDelay   = 60,
    parameter int WinScore     = 7
) (
    input  logic        BallClock,
    input  logic        Resetn,
    input  logic        Pause,
    input  logic [10:0] yLeftPaddle,
    input  logic [10:0] yRightPaddle,
    output logic [10:0] BallX,
    output logic [10:0] BallY,
    output logic [3:0]  ScoreLeft,
    output logic [3:0]  ScoreRight,
    output logic        PointLeft,
    output logic        PointRight,
    output logic        GameOver
);

    typedef enum logic [1:0] {S_Serve, S_Move, S_Score, S_Over} state_e;

    localparam int CW = (ServeDelay > 1) ? $clog2(ServeDelay) : 1;

    // Geometry constants widened to 12 bits so every sum below is overflow-free
    localparam logic [11:0] BALL_SZ  = 12'(BallSize);
    localparam logic [11:0] Y_TOP    = 12'(yTopBar);
    localparam logic [11:0] Y_BOT    = 12'(yBottomBar);
    localparam logic [11:0] PAD_H    = 12'(PaddleHeight);
    localparam logic [11:0] X_RPAD   = 12'(xRightPaddle);
    localparam logic [11:0] X_LFACE  = 12'(xLeftPaddle + PaddleWidth);
    localparam logic [11:0] X_RLIMIT = 12'(ScreenWidth - 1);
    localparam logic [10:0] X_INIT   = 11'(xBallInit);
    localparam logic [10:0] Y_INIT   = 11'(yBallInit);
    localparam logic [CW-1:0] CNT_LAST = CW'(ServeDelay - 1);
    localparam logic [3:0]  WIN      = 4'(WinScore);

    state_e        state_q, state_d;
    logic [10:0]   ball_x_q, ball_x_d;
    logic [10:0]   ball_y_q, ball_y_d;
    logic          dx_q, dx_d;          // 1 = moving right (+x)
    logic          dy_q, dy_d;          // 1 = moving down (+y)
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    score_l_q, score_l_d;
    logic [3:0]    score_r_q, score_r_d;
    logic          point_l_q, point_l_d;
    logic          point_r_q, point_r_d;
    logic          game_over_q, game_over_d;
    logic          scorer_left_q, scorer_left_d;

    logic [11:0] x12, y12, ly12, ry12;
    logic        at_bottom, at_top, left_ovl, right_ovl;
    logic        right_hit, left_hit, right_miss, left_miss;
    logic        serve_done;
    logic [3:0]  score_new;
    logic        win;

    assign x12  = {1'b0, ball_x_q};
    assign y12  = {1'b0, ball_y_q};
    assign ly12 = {1'b0, yLeftPaddle};
    assign ry12 = {1'b0, yRightPaddle};

    // Collision, miss and serve-timer decode from the current ball state
    always_comb begin
        at_bottom  = dy_q  && ((y12 + BALL_SZ) == Y_BOT);
        at_top     = !dy_q && (y12 == Y_TOP);
        right_ovl  = ((y12 + BALL_SZ) > ry12) && (y12 < (ry12 + PAD_H));
        left_ovl   = ((y12 + BALL_SZ) > ly12) && (y12 < (ly12 + PAD_H));
        right_hit  = dx_q  && ((x12 + BALL_SZ) == X_RPAD) && right_ovl;
        left_hit   = !dx_q && (x12 == X_LFACE) && left_ovl;
        right_miss = dx_q  && !right_hit && ((x12 + BALL_SZ) == X_RLIMIT);
        left_miss  = !dx_q && !left_hit && (x12 == 12'd0);
        serve_done = (cnt_q == CNT_LAST);
        score_new  = scorer_left_q ? (score_l_q + 4'd1) : (score_r_q + 4'd1);
        win        = (score_new == WIN);
    end

    // State register
    always_ff @(posedge BallClock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_Serve;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; Pause only freezes the serve and move phases
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_Serve: if (!Pause && serve_done) state_d = S_Move;
            S_Move:  if (!Pause && (right_miss || left_miss)) state_d = S_Score;
            S_Score: state_d = win ? S_Over : S_Serve;
            S_Over:  state_d = S_Over;
            default: state_d = S_Serve;
        endcase
    end

    // Datapath next values for ball, directions, serve counter, scores and pulses
    always_comb begin
        ball_x_d      = ball_x_q;
        ball_y_d      = ball_y_q;
        dx_d          = dx_q;
        dy_d          = dy_q;
        cnt_d         = cnt_q;
        score_l_d     = score_l_q;
        score_r_d     = score_r_q;
        game_over_d   = game_over_q;
        scorer_left_d = scorer_left_q;
        // Point pulses always self-clear so a pause right after a score cannot stretch them
        point_l_d     = 1'b0;
        point_r_d     = 1'b0;
        case (state_q)
            S_Serve: begin
                if (!Pause) cnt_d = serve_done ? '0 : cnt_q + 1'b1;
            end
            S_Move: begin
                if (!Pause) begin
                    if (right_miss || left_miss) begin
                        // Miss tick leaves the ball where it is; only the scorer is noted
                        scorer_left_d = right_miss;
                    end else begin
                        if (at_bottom || at_top) dy_d = ~dy_q;
                        else ball_y_d = dy_q ? ball_y_q + 11'd1 : ball_y_q - 11'd1;
                        if (right_hit || left_hit) dx_d = ~dx_q;
                        else ball_x_d = dx_q ? ball_x_q + 11'd1 : ball_x_q - 11'd1;
                    end
                end
            end
            S_Score: begin
                if (scorer_left_q) begin
                    score_l_d = score_new;
                    point_l_d = 1'b1;
                    dx_d      = 1'b1;   // serve toward the right player who conceded
                end else begin
                    score_r_d = score_new;
                    point_r_d = 1'b1;
                    dx_d      = 1'b0;
                end
                ball_x_d    = X_INIT;
                ball_y_d    = Y_INIT;
                cnt_d       = '0;
                game_over_d = win;
            end
            S_Over: begin
                game_over_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge BallClock or negedge Resetn) begin
        if (!Resetn) begin
            ball_x_q      <= X_INIT;
            ball_y_q      <= Y_INIT;
            dx_q          <= 1'b1;
            dy_q          <= 1'b1;
            cnt_q         <= '0;
            score_l_q     <= 4'd0;
            score_r_q     <= 4'd0;
            point_l_q     <= 1'b0;
            point_r_q     <= 1'b0;
            game_over_q   <= 1'b0;
            scorer_left_q <= 1'b0;
        end else begin
            ball_x_q      <= ball_x_d;
            ball_y_q      <= ball_y_d;
            dx_q          <= dx_d;
            dy_q          <= dy_d;
            cnt_q         <= cnt_d;
            score_l_q     <= score_l_d;
            score_r_q     <= score_r_d;
            point_l_q     <= point_l_d;
            point_r_q     <= point_r_d;
            game_over_q   <= game_over_d;
            scorer_left_q <= scorer_left_d;
        end
    end

    assign BallX      = ball_x_q;
    assign BallY      = ball_y_q;
    assign ScoreLeft  = score_l_q;
    assign ScoreRight = score_r_q;
    assign PointLeft  = point_l_q;
    assign PointRight = point_r_q;
    assign GameOver   = game_over_q;

endmodule

// File: tb/tb_ball_motion.sv
// tb/tb_ball_motion.sv - self-checking bench for ball_motion
module tb_ball_motion;

    localparam int W = 1280, YT = 100, YB = 924, PH = 200, PW = 20;
    localparam int XL = 40, XR = 1220, BS = 16, X0 = 632, Y0 = 504, SD = 60, WIN = 7;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        pause = 1'b0;
    logic [10:0] ly = 11'd0;
    logic [10:0] ry = 11'd700;
    logic [10:0] bx, by;
    logic [3:0]  sl, sr;
    logic        pl, pr, go;

    always #5 clk = ~clk;

    ball_motion dut (
        .BallClock(clk), .Resetn(rstn), .Pause(pause),
        .yLeftPaddle(ly), .yRightPaddle(ry),
        .BallX(bx), .BallY(by), .ScoreLeft(sl), .ScoreRight(sr),
        .PointLeft(pl), .PointRight(pr), .GameOver(go)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: game rules in plain integer arithmetic
    int m_x, m_y, m_vx, m_vy, m_sl, m_sr, m_wait, m_pend;
    int m_pl, m_pr, m_over;

    function automatic void model_reset();
        m_x = X0; m_y = Y0; m_vx = 1; m_vy = 1;
        m_sl = 0; m_sr = 0; m_wait = SD; m_pend = 0;
        m_pl = 0; m_pr = 0; m_over = 0;
    endfunction

    function automatic void model_step(input int p, input int lyv, input int ryv);
        int nx, ny, nvx, nvy;
        m_pl = 0; m_pr = 0;
        if (m_over != 0) return;
        if (m_pend != 0) begin
            if (m_pend == 1) begin m_sl++; m_pl = 1; m_vx = 1; end
            else begin m_sr++; m_pr = 1; m_vx = -1; end
            m_pend = 0; m_x = X0; m_y = Y0;
            if (m_sl == WIN || m_sr == WIN) m_over = 1;
            else m_wait = SD;
            return;
        end
        if (p != 0) return;
        if (m_wait > 0) begin m_wait--; return; end
        nx = m_x; ny = m_y; nvx = m_vx; nvy = m_vy;
        if (m_vy > 0) begin
            if (m_y + BS == YB) nvy = -1; else ny = m_y + 1;
        end else begin
            if (m_y == YT) nvy = 1; else ny = m_y - 1;
        end
        if (m_vx > 0) begin
            if (m_x + BS == XR && m_y + BS > ryv && m_y < ryv + PH) nvx = -1;
            else if (m_x + BS == W - 1) m_pend = 1;
            else nx = m_x + 1;
        end else begin
            if (m_x == XL + PW && m_y + BS > lyv && m_y < lyv + PH) nvx = 1;
            else if (m_x == 0) m_pend = 2;
            else nx = m_x - 1;
        end
        if (m_pend == 0) begin
            m_x = nx; m_y = ny; m_vx = nvx; m_vy = nvy;
        end
    endfunction

    task automatic tick();
        model_step(int'(pause), int'(ly), int'(ry));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input int ex, input int ey, input int esl,
                              input int esr, input int epl, input int epr, input int eo);
        logic ok;
        ok = (bx == 11'(ex)) && (by == 11'(ey)) && (sl == 4'(esl)) && (sr == 4'(esr)) &&
             (pl == 1'(epl)) && (pr == 1'(epr)) && (go == 1'(eo));
        vectors++;
        if (ok !== 1'b1) begin
            miscompares++;
            $display("FAIL %s: got x=%0d y=%0d sl=%0d sr=%0d pl=%0d pr=%0d go=%0d, expected x=%0d y=%0d sl=%0d sr=%0d pl=%0d pr=%0d go=%0d",
                     name, bx, by, sl, sr, pl, pr, go, ex, ey, esl, esr, epl, epr, eo);
        end
    endtask

    typedef struct {
        int rst; int cycles; int p; int lyv; int ryv;
        int ex; int ey; int esl; int esr; int epl; int epr; int eo;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input int rst, input int cyc, input int p, input int lyv, input int ryv,
                       input int ex, input int ey, input int esl, input int esr,
                       input int epl, input int epr, input int eo);
        vec_t v;
        v.rst = rst; v.cycles = cyc; v.p = p; v.lyv = lyv; v.ryv = ryv;
        v.ex = ex; v.ey = ey; v.esl = esl; v.esr = esr; v.epl = epl; v.epr = epr; v.eo = eo;
        tbl.push_back(v);
    endtask

    initial begin
        int pulses, wide, prev, late;

        // Serve timing, bottom bounce, right paddle hit
        add(1,   0, 0, 0, 700,  632, 504, 0, 0, 0, 0, 0);
        add(0,  60, 0, 0, 700,  632, 504, 0, 0, 0, 0, 0);
        add(0,   1, 0, 0, 700,  633, 505, 0, 0, 0, 0, 0);
        add(0, 403, 0, 0, 700, 1036, 908, 0, 0, 0, 0, 0);
        add(0,   1, 0, 0, 700, 1037, 908, 0, 0, 0, 0, 0);
        add(0,   1, 0, 0, 700, 1038, 907, 0, 0, 0, 0, 0);
        add(0, 166, 0, 0, 700, 1204, 741, 0, 0, 0, 0, 0);
        add(0,   1, 0, 0, 700, 1204, 740, 0, 0, 0, 0, 0);
        add(0,   1, 0, 0, 700, 1203, 739, 0, 0, 0, 0, 0);
        // Right miss, score tick, re-serve
        add(1, 691, 0, 0, 100, 1263, 682, 0, 0, 0, 0, 0);
        add(0,   1, 0, 0, 100, 1263, 682, 0, 0, 0, 0, 0);
        add(0,   1, 0, 0, 100,  632, 504, 1, 0, 1, 0, 0);
        add(0,   1, 0, 0, 100,  632, 504, 1, 0, 0, 0, 0);
        add(0,  59, 0, 0, 100,  632, 504, 1, 0, 0, 0, 0);
        add(0,   1, 0, 0, 100,  633, 503, 1, 0, 0, 0, 0);
        // Pause mid-flight and during serve
        add(1, 100, 0, 0, 700,  672, 544, 0, 0, 0, 0, 0);
        add(0,  50, 1, 0, 700,  672, 544, 0, 0, 0, 0, 0);
        add(0,   1, 0, 0, 700,  673, 545, 0, 0, 0, 0, 0);
        add(1,  30, 0, 0, 700,  632, 504, 0, 0, 0, 0, 0);
        add(0,  40, 1, 0, 700,  632, 504, 0, 0, 0, 0, 0);
        add(0,  30, 0, 0, 700,  632, 504, 0, 0, 0, 0, 0);
        add(0,   1, 0, 0, 700,  633, 505, 0, 0, 0, 0, 0);

        model_reset();
        foreach (tbl[i]) begin
            if (tbl[i].rst != 0) do_reset();
            pause = 1'(tbl[i].p);
            ly = 11'(tbl[i].lyv);
            ry = 11'(tbl[i].ryv);
            repeat (tbl[i].cycles) tick();
            check_outs($sformatf("table[%0d]", i), tbl[i].ex, tbl[i].ey, tbl[i].esl, tbl[i].esr,
                       tbl[i].epl, tbl[i].epr, tbl[i].eo);
        end

        // Async reset mid-flight takes effect before the next clock edge
        do_reset();
        pause = 1'b0; ly = 11'd0; ry = 11'd700;
        repeat (200) tick();
        check_outs("flight_before_reset", 772, 644, 0, 0, 0, 0, 0);
        #3 rstn = 1'b0;
        #1 check_outs("async_reset_flight", 632, 504, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        model_reset();

        // Seven right-side misses end the game
        ry = 11'd1000; ly = 11'd0; pause = 1'b0;
        pulses = 0; wide = 0; prev = 0; late = 0;
        for (int i = 0; i < 6000 && go !== 1'b1; i++) begin
            tick();
            if (pl === 1'b1) begin
                pulses++;
                if (prev != 0) wide++;
            end
            prev = int'(pl);
        end
        check("gameover_reached", int'(go), 1);
        check("left_pulse_count", pulses, 7);
        check("pulse_width_one", wide, 0);
        check_outs("gameover_state", 632, 504, 7, 0, 1, 0, 1);
        for (int i = 0; i < 100; i++) begin
            pause = 1'(i % 3 == 0);
            tick();
            if (pl === 1'b1 || pr === 1'b1) late++;
        end
        pause = 1'b0;
        check("pulses_after_over", late, 0);
        check_outs("gameover_frozen", 632, 504, 7, 0, 0, 0, 1);
        #3 rstn = 1'b0;
        #1 check_outs("async_reset_over", 632, 504, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        model_reset();

        // Randomized play against the reference model
        for (int ep = 0; ep < 4; ep++) begin
            do_reset();
            ly = 11'($urandom_range(0, 900));
            ry = 11'($urandom_range(0, 900));
            for (int c = 0; c < 6000; c++) begin
                if ($urandom_range(0, 47) == 0) ly = 11'($urandom_range(0, 1100));
                if ($urandom_range(0, 47) == 0) ry = 11'($urandom_range(0, 1100));
                pause = 1'((ep != 0) && ($urandom_range(0, 9) == 0));
                tick();
                check_outs($sformatf("rand ep%0d cyc%0d", ep, c), m_x, m_y, m_sl, m_sr, m_pl, m_pr, m_over);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
